dmem_arbiter: RTL

- Two-port arbiter that shares the single data memory between the CPU load/store path and a DMA/debug requester.
- CPU has default priority; a starvation counter forces a DMA win after STARVE_LIMIT consecutive denied DMA cycles.
- Same-cycle combinational grant; memory control is driven from the winner.
- Read data is registered and returned to the winning requester one cycle later with a valid strobe.

---
 rtl/dmem_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter sharing one data memory, registered read return
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} pend_t;

  pend_t      pend_q, pend_d;
  logic [3:0] wait_cnt;
  logic       starved;

  assign starved = (wait_cnt == LIMIT);

  // Grants are gated by reset so an access in flight is dropped immediately.
  always_comb begin
    cpu_gnt = ~reset & cpu_req & (~dma_req | ~starved);
    dma_gnt = ~reset & dma_req & (~cpu_req | starved);
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (cpu_gnt) begin
      mem_read       = ~cpu_we;
      mem_write      = cpu_we;
      mem_address    = cpu_addr;
      mem_write_data = cpu_wdata;
    end else if (dma_gnt) begin
      mem_read       = ~dma_we;
      mem_write      = dma_we;
      mem_address    = dma_addr;
      mem_write_data = dma_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (dma_req & ~dma_gnt) begin
      if (!starved) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= IDLE;
    else       pend_q <= pend_d;
  end

  always_comb begin
    pend_d = IDLE;
    if (cpu_gnt && !cpu_we)      pend_d = CPU_RD;
    else if (dma_gnt && !dma_we) pend_d = DMA_RD;
  end

  always_comb begin
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    case (pend_q)
      CPU_RD:  cpu_rvalid = 1'b1;
      DMA_RD:  dma_rvalid = 1'b1;
      default: ;
    endcase
  end

  // Each requester keeps its last read word until its next granted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_read_data;
      if (dma_gnt && !dma_we) dma_rdata <= mem_read_data;
    end
  end

endmodule
